// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge loader: FSM states,
// bankswitch codes and SuperChip mode encodings.
package cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam logic [3:0] BS_NONE = 4'd0;
    localparam logic [3:0] BS_F8   = 4'd1;
    localparam logic [3:0] BS_F6   = 4'd2;
    localparam logic [3:0] BS_FE   = 4'd3;
    localparam logic [3:0] BS_E0   = 4'd4;
    localparam logic [3:0] BS_3F   = 4'd5;
    localparam logic [3:0] BS_F4   = 4'd6;
    localparam logic [3:0] BS_P2   = 4'd7;
    localparam logic [3:0] BS_FA   = 4'd8;
    localparam logic [3:0] BS_CV   = 4'd9;

    localparam logic [1:0] SC_AUTO = 2'd0;
    localparam logic [1:0] SC_OFF  = 2'd1;
    localparam logic [1:0] SC_ON   = 2'd2;

    localparam int          SCAN_LEN    = 256;
    localparam int          SC_MIN_SIZE = 8192;
    localparam logic [16:0] SIZE_MAX    = 17'h1FFFF;

endpackage

// File: rtl/cart_ext_decode.sv
// Maps the file extension of the downloaded image to a forced bankswitch
// scheme code; unknown extensions select no forcing.
module cart_ext_decode
    import cart_pkg::*;
(
    input  logic [31:0] file_ext,
    output logic [3:0]  bank_sw
);

    logic [23:0] ext;

    always_comb begin
        // Three-letter names arrive right-aligned; four-letter ones carry a suffix byte.
        ext = (file_ext[23:16] == 8'h2E) ? file_ext[23:0] : file_ext[31:8];
        case (ext)
            ".F8":   bank_sw = BS_F8;
            ".F6":   bank_sw = BS_F6;
            ".FE":   bank_sw = BS_FE;
            ".E0":   bank_sw = BS_E0;
            ".3F":   bank_sw = BS_3F;
            ".F4":   bank_sw = BS_F4;
            ".P2":   bank_sw = BS_P2;
            ".FA":   bank_sw = BS_FA;
            ".CV":   bank_sw = BS_CV;
            default: bank_sw = BS_NONE;
        endcase
    end

endmodule

// File: rtl/cart_loader.sv
// Cartridge loader: writes the HPS download into cart ROM, optionally scans
// the first page for SuperChip padding, then publishes the cart configuration.
//
// state | meaning
// IDLE  | waiting for a download rising edge; outputs hold last config
// LOAD  | forwarding download writes to ROM, tracking image size
// SCAN  | reading bytes 0..255 and comparing them against byte 0
// DONE  | one-cycle commit of rom_size/force_bs/sc, done pulse
module cart_loader
    import cart_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [31:0] ioctl_file_ext,
    input  logic [1:0]  sc_mode,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_q,
    output logic [16:0] rom_size,
    output logic [3:0]  force_bs,
    output logic        sc,
    output logic        core_reset,
    output logic        busy,
    output logic        done
);

    state_t      state, state_nxt;
    logic        dl_q;
    logic        dl_rise, dl_fall;
    logic [16:0] size;
    logic [16:0] wr_end;
    logic        scan_hit;
    logic [8:0]  scan_left;
    logic [8:0]  scan_idx;
    logic [7:0]  byte0;
    logic [1:0]  mode_q;
    logic [31:0] ext_q;
    logic [3:0]  bs_dec;
    logic        sc_dec;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    assign wr_end   = ((|ioctl_addr[24:17]) || (ioctl_addr[16:0] == SIZE_MAX)) ?
                      SIZE_MAX : ioctl_addr[16:0] + 17'd1;
    assign scan_idx = 9'(SCAN_LEN) - scan_left;

    assign busy       = (state != ST_IDLE);
    assign core_reset = busy;

    cart_ext_decode u_ext_decode (
        .file_ext (ext_q),
        .bank_sw  (bs_dec)
    );

    always_comb begin
        case (mode_q)
            SC_AUTO: sc_dec = (ext_q[7:0] == "S") | scan_hit;
            SC_OFF:  sc_dec = 1'b0;
            default: sc_dec = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ram_addr  = '0;
        ram_din   = '0;
        ram_we    = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dl_rise) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                ram_addr = ioctl_addr[14:0];
                ram_din  = ioctl_dout;
                ram_we   = ioctl_wr & ~(|ioctl_addr[24:15]);
                if (dl_fall)
                    state_nxt = (size >= 17'(SC_MIN_SIZE) && mode_q == SC_AUTO) ?
                                ST_SCAN : ST_DONE;
            end
            ST_SCAN: begin
                ram_addr = {7'd0, scan_idx[7:0]};
                if (dl_rise)
                    state_nxt = ST_LOAD;
                else if (scan_left == 9'd0)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // A restart arriving in the commit cycle wins; no commit, no pulse.
                done      = ~dl_rise;
                state_nxt = dl_rise ? ST_LOAD : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            dl_q      <= 1'b1; // a download still high after reset is not a new edge
            size      <= '0;
            scan_hit  <= 1'b0;
            scan_left <= '0;
            byte0     <= '0;
            mode_q    <= SC_AUTO;
            ext_q     <= '0;
            rom_size  <= '0;
            force_bs  <= '0;
            sc        <= 1'b0;
        end else begin
            state <= state_nxt;
            dl_q  <= ioctl_download;
            if (state_nxt == ST_LOAD && state != ST_LOAD) begin
                size     <= '0;
                scan_hit <= 1'b0;
                mode_q   <= sc_mode;
                ext_q    <= ioctl_file_ext;
            end else if (state == ST_LOAD) begin
                if (ioctl_wr && wr_end > size) size <= wr_end;
                if (state_nxt == ST_SCAN) begin
                    scan_left <= 9'(SCAN_LEN);
                    scan_hit  <= 1'b1;
                end
            end else if (state == ST_SCAN) begin
                scan_left <= scan_left - 9'd1;
                // ram_q lags ram_addr by one cycle, so byte 0 lands one step after entry.
                if (scan_left == 9'(SCAN_LEN - 1))
                    byte0 <= ram_q;
                else if (scan_left < 9'(SCAN_LEN - 1) && ram_q != byte0)
                    scan_hit <= 1'b0;
            end else if (state == ST_DONE) begin
                rom_size <= size;
                force_bs <= bs_dec;
                sc       <= sc_dec;
            end
        end
    end

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader with a behavioural dual-port ROM model.
module tb_cart_loader;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [31:0] ioctl_file_ext;
    logic [1:0]  sc_mode;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic [16:0] rom_size;
    logic [3:0]  force_bs;
    logic        sc;
    logic        core_reset;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] mem [0:32767];

    cart_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_file_ext (ioctl_file_ext),
        .sc_mode        (sc_mode),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .ram_q          (ram_q),
        .rom_size       (rom_size),
        .force_bs       (force_bs),
        .sc             (sc),
        .core_reset     (core_reset),
        .busy           (busy),
        .done           (done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i, input int diff);
        if (i == diff) return 8'h00;
        if (i < 256) return 8'hFF;
        return 8'(i * 7 + 3);
    endfunction

    task automatic begin_dl(input logic [31:0] ext, input logic [1:0] mode);
        sc_mode        = mode;
        ioctl_file_ext = ext;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic write_bytes(input int n, input int diff);
        for (int i = 0; i < n; i++) begin
            ioctl_addr = 25'(i);
            ioctl_dout = pat(i, diff);
            ioctl_wr   = 1'b1;
            @(negedge clk_sys);
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic end_dl(input string tag, input int exp_lat, input logic [16:0] exp_size,
                          input logic [3:0] exp_bs, input logic exp_sc);
        int lat;
        ioctl_download = 1'b0;
        lat = 0;
        do begin
            @(negedge clk_sys);
            lat++;
        end while (!done && lat < 1000);
        chk({tag, "_done_latency"}, lat, exp_lat);
        @(negedge clk_sys);
        chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
        chk({tag, "_rom_size"}, {15'd0, rom_size}, {15'd0, exp_size});
        chk({tag, "_force_bs"}, {28'd0, force_bs}, {28'd0, exp_bs});
        chk({tag, "_sc"}, {31'd0, sc}, {31'd0, exp_sc});
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic saw_done;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_file_ext = '0;
        sc_mode        = 2'd0;
        repeat (3) @(negedge clk_sys);
        chk("rst_rom_size", {15'd0, rom_size}, 32'd0);
        chk("rst_force_bs", {28'd0, force_bs}, 32'd0);
        chk("rst_sc", {31'd0, sc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_core_reset", {31'd0, core_reset}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // stray write while idle
        ioctl_addr = 25'h10;
        ioctl_dout = 8'hA5;
        ioctl_wr   = 1'b1;
        #1;
        chk("idle_ram_we", {31'd0, ram_we}, 32'd0);
        chk("idle_ram_addr", {17'd0, ram_addr}, 32'd0);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;

        // 8K .F8, first page all 0xFF, auto mode -> scan hit
        begin_dl({8'h00, ".F8"}, 2'd0);
        chk("f8_busy", {31'd0, busy}, 32'd1);
        chk("f8_core_reset", {31'd0, core_reset}, 32'd1);
        write_bytes(8192, 300);
        end_dl("f8", 258, 17'd8192, 4'd1, 1'b1);

        // 4K .BIN, auto -> scan skipped
        begin_dl(".BIN", 2'd0);
        write_bytes(4096, 300);
        ioctl_addr = 25'd10;
        ioctl_dout = pat(10, 300);
        ioctl_wr   = 1'b1;
        #1;
        chk("bin_ram_we", {31'd0, ram_we}, 32'd1);
        chk("bin_ram_addr", {17'd0, ram_addr}, 32'd10);
        chk("bin_ram_din", {24'd0, ram_din}, 32'hFF);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        end_dl("bin", 1, 17'd4096, 4'd0, 1'b0);

        // 16K .F6 with byte 100 different, auto -> scan miss
        begin_dl({8'h00, ".F6"}, 2'd0);
        write_bytes(16384, 100);
        end_dl("f6_auto", 258, 17'd16384, 4'd2, 1'b0);

        // same image, forced SuperChip -> no scan
        begin_dl({8'h00, ".F6"}, 2'd2);
        write_bytes(16384, 100);
        end_dl("f6_on", 1, 17'd16384, 4'd2, 1'b1);

        // write beyond the ROM window
        begin_dl({8'h00, ".FE"}, 2'd1);
        ioctl_addr = 25'h8005;
        ioctl_dout = 8'h5A;
        ioctl_wr   = 1'b1;
        #1;
        chk("x8005_ram_we", {31'd0, ram_we}, 32'd0);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        end_dl("x8005", 1, 17'h08006, 4'd3, 1'b0);

        // size saturation at the top of the address space
        begin_dl({8'h00, ".P2"}, 2'd1);
        ioctl_addr = 25'h1FFFFFF;
        ioctl_dout = 8'h11;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        end_dl("sat", 1, 17'h1FFFF, 4'd7, 1'b0);

        // zero-write download with "S" suffix
        begin_dl(".E0S", 2'd0);
        end_dl("zero", 1, 17'd0, 4'd4, 1'b1);

        // restart during SCAN
        begin_dl({8'h00, ".3F"}, 2'd0);
        write_bytes(8192, 300);
        ioctl_download = 1'b0;
        saw_done = 1'b0;
        repeat (50) begin
            @(negedge clk_sys);
            if (done) saw_done = 1'b1;
        end
        chk("abort_in_scan_busy", {31'd0, busy}, 32'd1);
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        begin_dl({8'h00, ".F4"}, 2'd1);
        chk("abort_reload_busy", {31'd0, busy}, 32'd1);
        chk("abort_hold_rom_size", {15'd0, rom_size}, 32'd0);
        chk("abort_hold_force_bs", {28'd0, force_bs}, 32'd4);
        chk("abort_hold_sc", {31'd0, sc}, 32'd1);
        write_bytes(4096, 300);
        end_dl("abort_new", 1, 17'd4096, 4'd6, 1'b0);

        // reset in the middle of LOAD
        begin_dl({8'h00, ".FA"}, 2'd0);
        write_bytes(100, 300);
        ioctl_addr = 25'h123;
        ioctl_dout = 8'h77;
        ioctl_wr   = 1'b1;
        reset_n    = 1'b0;
        #1;
        chk("mid_rst_rom_size", {15'd0, rom_size}, 32'd0);
        chk("mid_rst_force_bs", {28'd0, force_bs}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_core_reset", {31'd0, core_reset}, 32'd0);
        chk("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("mid_rst_ram_addr", {17'd0, ram_addr}, 32'd0);
        chk("mid_rst_ram_din", {24'd0, ram_din}, 32'd0);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk_sys);
            if (done || busy) saw_done = 1'b1;
        end
        ioctl_download = 1'b0;
        repeat (20) begin
            @(negedge clk_sys);
            if (done || busy) saw_done = 1'b1;
        end
        chk("post_rst_stays_idle", {31'd0, saw_done}, 32'd0);
        chk("post_rst_sc", {31'd0, sc}, 32'd0);

        // loader still usable after reset
        begin_dl({8'h00, ".CV"}, 2'd3);
        end_dl("cv", 1, 17'd0, 4'd9, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
